// File: rtl/cache_arb_types.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : cache_arb_types                                         |
// | Description: Shared types and default widths for the cache arbiter.  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package cache_arb_types;

    localparam int c_line_w_default = 256;
    localparam int c_addr_w_default = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

endpackage
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : arb_rr2                                                 |
// | Description: 2-way round-robin picker holding the last-grant state.  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module arb_rr2
    import cache_arb_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i,
    input  logic       req_d,
    input  logic       update,
    output requester_t grant,
    output logic       valid
);

    requester_t r_last;

    always_comb begin
        valid = req_i | req_d;
        grant = REQ_I;
        if (req_i && req_d) begin
            // On a tie the side that did not win last time goes first
            grant = (r_last == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            grant = REQ_D;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= REQ_I;
        end else if (update && valid) begin
            r_last <= grant;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : cache_arbiter                                           |
// | Description: Shares one memory line port between icache and dcache.  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module cache_arbiter
    import cache_arb_types::*;
#(
    parameter int s_line = c_line_w_default,
    parameter int s_addr = c_addr_w_default
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [s_addr-1:0] i_address,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [s_line-1:0] i_wdata,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    input  logic [s_addr-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    output logic [s_addr-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    state_t      r_state;
    requester_t  r_grant;
    requester_t  w_pick;
    logic        w_pick_valid;
    logic        w_sel_write;

    arb_rr2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req_i  (i_read | i_write),
        .req_d  (d_read | d_write),
        .update (r_state == IDLE),
        .grant  (w_pick),
        .valid  (w_pick_valid)
    );

    // A requester asserting read and write together is treated as a write
    assign w_sel_write = (w_pick == REQ_D) ? d_write : i_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_grant      <= REQ_I;
            pmem_address <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_wdata   <= '0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant      <= w_pick;
                        pmem_address <= (w_pick == REQ_D) ? d_address : i_address;
                        pmem_wdata   <= (w_pick == REQ_D) ? d_wdata : i_wdata;
                        pmem_write   <= w_sel_write;
                        pmem_read    <= ~w_sel_write;
                        r_state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        if (r_grant == REQ_D) begin
                            d_resp <= 1'b1;
                            if (pmem_read) begin
                                d_rdata <= pmem_rdata;
                            end
                        end else begin
                            i_resp <= 1'b1;
                            if (pmem_read) begin
                                i_rdata <= pmem_rdata;
                            end
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Requests are not looked at here so the winner can drop its level
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_cache_arbiter                                        |
// | Description: Directed self-checking bench for cache_arbiter.         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_cache_arbiter;

    localparam int c_line = 256;
    localparam int c_addr = 32;

    logic              clk;
    logic              rst;
    logic [c_addr-1:0] i_address, d_address, pmem_address;
    logic              i_read, i_write, d_read, d_write;
    logic [c_line-1:0] i_wdata, d_wdata, i_rdata, d_rdata, pmem_wdata, pmem_rdata;
    logic              i_resp, d_resp, pmem_read, pmem_write, pmem_resp;

    int n_vec = 0;
    int n_err = 0;

    logic [c_line-1:0] c_aa, c_55, c_33, c_cc;

    cache_arbiter #(.s_line(c_line), .s_addr(c_addr)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_address    (i_address),
        .i_read       (i_read),
        .i_write      (i_write),
        .i_wdata      (i_wdata),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_address    (d_address),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        i_address = '0; i_read = 0; i_write = 0; i_wdata = '0;
        d_address = '0; d_read = 0; d_write = 0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    // Pulse pmem_resp for one edge; afterwards outputs reflect the completion
    task automatic mem_reply(input logic [c_line-1:0] data);
        pmem_rdata = data;
        pmem_resp  = 1'b1;
        tick();
        pmem_resp  = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        n_vec++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b want=0000", {pmem_read, pmem_write, i_resp, d_resp});
        end
        n_vec++;
        if (pmem_address !== '0 || pmem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_data addr=%h wd_nz=%0d ird_nz=%0d drd_nz=%0d want all 0",
                     pmem_address, pmem_wdata != '0, i_rdata != '0, d_rdata != '0);
        end
    endtask

    task automatic test_i_read;
        i_address = 32'h1000_0040; i_read = 1;
        tick();
        n_vec++;
        if (pmem_read !== 1 || pmem_write !== 0 || pmem_address !== 32'h1000_0040) begin
            n_err++;
            $display("FAIL iread_issue rd=%b wr=%b addr=%h want 1 0 10000040", pmem_read, pmem_write, pmem_address);
        end
        repeat (3) tick();
        mem_reply(c_aa);
        n_vec++;
        if (i_resp !== 1 || d_resp !== 0 || i_rdata !== c_aa || pmem_read !== 0) begin
            n_err++;
            $display("FAIL iread_done iresp=%b dresp=%b rdata_ok=%b prd=%b want 1 0 1 0",
                     i_resp, d_resp, i_rdata === c_aa, pmem_read);
        end
        i_read = 0;
        tick();
        n_vec++;
        if (i_resp !== 0 || d_rdata !== '0) begin
            n_err++;
            $display("FAIL iread_pulse iresp=%b drd_nz=%b want 0 0", i_resp, d_rdata != '0);
        end
        tick();
    endtask

    task automatic test_tie;
        apply_reset();
        i_address = 32'h100; i_read = 1;
        d_address = 32'h200; d_write = 1; d_wdata = c_55;
        tick();
        n_vec++;
        if (pmem_write !== 1 || pmem_read !== 0 || pmem_address !== 32'h200 || pmem_wdata !== c_55) begin
            n_err++;
            $display("FAIL tie_first wr=%b rd=%b addr=%h wd_ok=%b want 1 0 200 1",
                     pmem_write, pmem_read, pmem_address, pmem_wdata === c_55);
        end
        mem_reply(c_cc);
        n_vec++;
        if (d_resp !== 1 || i_resp !== 0 || d_rdata !== '0) begin
            n_err++;
            $display("FAIL tie_dwrite_done dresp=%b iresp=%b drd_nz=%b want 1 0 0", d_resp, i_resp, d_rdata != '0);
        end
        d_write = 0;
        repeat (2) tick();
        n_vec++;
        if (pmem_read !== 1 || pmem_address !== 32'h100) begin
            n_err++;
            $display("FAIL tie_second rd=%b addr=%h want 1 100", pmem_read, pmem_address);
        end
        mem_reply(c_33);
        n_vec++;
        if (i_resp !== 1 || i_rdata !== c_33) begin
            n_err++;
            $display("FAIL tie_iread_done iresp=%b rdata_ok=%b want 1 1", i_resp, i_rdata === c_33);
        end
        // Both held high: grants must go D, I, D, I
        d_read = 1;
        for (int k = 0; k < 4; k++) begin
            logic want_d;
            want_d = (k % 2 == 0);
            repeat (2) tick();
            n_vec++;
            if (pmem_read !== 1 || pmem_address !== (want_d ? 32'h200 : 32'h100)) begin
                n_err++;
                $display("FAIL tie_alt%0d rd=%b addr=%h want 1 %h", k, pmem_read, pmem_address,
                         want_d ? 32'h200 : 32'h100);
            end
            mem_reply(c_aa);
            n_vec++;
            if (d_resp !== want_d || i_resp !== !want_d) begin
                n_err++;
                $display("FAIL tie_alt%0d_resp d=%b i=%b want %b %b", k, d_resp, i_resp, want_d, !want_d);
            end
        end
        i_read = 0; d_read = 0;
        repeat (2) tick();
    endtask

    task automatic test_rw_same;
        logic [c_line-1:0] prev;
        prev = i_rdata;
        i_address = 32'h300; i_read = 1; i_write = 1; i_wdata = c_cc;
        tick();
        n_vec++;
        if (pmem_write !== 1 || pmem_read !== 0 || pmem_address !== 32'h300) begin
            n_err++;
            $display("FAIL rw_same wr=%b rd=%b addr=%h want 1 0 300", pmem_write, pmem_read, pmem_address);
        end
        mem_reply(c_55);
        n_vec++;
        if (i_resp !== 1 || i_rdata !== prev) begin
            n_err++;
            $display("FAIL rw_same_done iresp=%b rdata_held=%b want 1 1", i_resp, i_rdata === prev);
        end
        i_read = 0; i_write = 0;
        repeat (2) tick();
    endtask

    task automatic test_mid_busy;
        d_address = 32'h200; d_read = 1;
        tick();
        d_address = 32'h400; i_address = 32'h500; i_read = 1;
        repeat (2) tick();
        n_vec++;
        if (pmem_address !== 32'h200 || pmem_read !== 1) begin
            n_err++;
            $display("FAIL busy_hold addr=%h rd=%b want 200 1", pmem_address, pmem_read);
        end
        mem_reply(c_33);
        n_vec++;
        if (d_resp !== 1 || d_rdata !== c_33 || i_resp !== 0) begin
            n_err++;
            $display("FAIL busy_done dresp=%b rdata_ok=%b iresp=%b want 1 1 0", d_resp, d_rdata === c_33, i_resp);
        end
        d_read = 0;
        tick();
        n_vec++;
        if (pmem_read !== 0) begin
            n_err++;
            $display("FAIL busy_done_gap rd=%b want 0", pmem_read);
        end
        tick();
        n_vec++;
        if (pmem_read !== 1 || pmem_address !== 32'h500) begin
            n_err++;
            $display("FAIL busy_next rd=%b addr=%h want 1 500", pmem_read, pmem_address);
        end
        i_read = 0;
        mem_reply(c_aa);
        n_vec++;
        if (i_resp !== 1) begin
            n_err++;
            $display("FAIL busy_drop_resp iresp=%b want 1", i_resp);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_op;
        d_address = 32'h600; d_read = 1;
        tick();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0 || pmem_address !== '0 ||
            i_rdata !== '0 || d_rdata !== '0) begin
            n_err++;
            $display("FAIL rst_async ctrl=%b addr=%h want 0000 0", {pmem_read, pmem_write, i_resp, d_resp}, pmem_address);
        end
        d_read = 0;
        tick();
        rst = 1'b1;
        tick();
        mem_reply(c_aa);
        n_vec++;
        if (i_resp !== 0 || d_resp !== 0 || d_rdata !== '0) begin
            n_err++;
            $display("FAIL rst_stale_resp iresp=%b dresp=%b drd_nz=%b want 0 0 0", i_resp, d_resp, d_rdata != '0);
        end
    endtask

    task automatic test_spurious;
        mem_reply(c_55);
        n_vec++;
        if (i_resp !== 0 || d_resp !== 0 || pmem_read !== 0) begin
            n_err++;
            $display("FAIL spurious iresp=%b dresp=%b rd=%b want 0 0 0", i_resp, d_resp, pmem_read);
        end
        i_address = 32'h700; i_read = 1;
        tick();
        n_vec++;
        if (pmem_read !== 1 || pmem_address !== 32'h700) begin
            n_err++;
            $display("FAIL spurious_idle rd=%b addr=%h want 1 700", pmem_read, pmem_address);
        end
        i_read = 0;
        mem_reply(c_33);
        repeat (2) tick();
    endtask

    initial begin
        c_aa = {32{8'hAA}};
        c_55 = {32{8'h55}};
        c_33 = {32{8'h33}};
        c_cc = {32{8'hCC}};
        test_reset();
        test_i_read();
        test_tie();
        test_rw_same();
        test_mid_busy();
        test_reset_mid_op();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache and the data cache.
- Each cache presents a 256-bit line read/write interface. The arbiter grants one requester at a time and drives the memory request from registers.
- Returns the memory response to the granted cache only.
- Sits between both cache instances and the memory/bus adapter.

Parameters:
s_line, 256, line width in bits (data buses)
s_addr, 32, address width in bits

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
i_address  input  s_addr  icache line address
i_read  input  1  icache line read request (level, held until i_resp)
i_write  input  1  icache line write request (level, held until i_resp)
i_wdata  input  s_line  icache write line
i_rdata  output  s_line  line returned to icache
i_resp  output  1  one-cycle completion pulse to icache
d_address  input  s_addr  dcache line address
d_read  input  1  dcache line read request
d_write  input  1  dcache line write request (writeback)
d_wdata  input  s_line  dcache write line
d_rdata  output  s_line  line returned to dcache
d_resp  output  1  one-cycle completion pulse to dcache
pmem_address  output  s_addr  memory line address (registered)
pmem_read  output  1  memory read request (registered)
pmem_write  output  1  memory write request (registered)
pmem_wdata  output  s_line  memory write line (registered)
pmem_rdata  input  s_line  memory read line
pmem_resp  input  1  memory completion, one cycle

Behaviour:
- Reset (rst=0, async): state IDLE, last_grant=I. All outputs 0: pmem_*, i_rdata, d_rdata, i_resp, d_resp. Any in-flight memory transaction is abandoned; no resp is issued for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req_X = X_read|X_write.
  - Only one requester asks: grant it.
  - Both ask: grant the requester that is not last_grant (round-robin). After reset the first tie goes to D.
  - On grant, capture address, wdata and op into the pmem_* registers, set last_grant, go to BUSY. pmem_read/pmem_write are visible the cycle after the request is sampled (1-cycle latency).
- Operation select: read and write both high from one requester -> write wins.
- BUSY:
  - pmem_address, pmem_wdata and the op bit are held stable.
  - New or changed requests are ignored.
  - On pmem_resp=1: drop pmem_read/pmem_write at the next edge. Register pmem_rdata into the granted X_rdata (writes leave it unchanged). Pulse X_resp for exactly one cycle. Go to DONE.
- DONE (1 cycle):
  - Requests are not sampled, so the finished requester can deassert before re-arbitration.
  - Next state is IDLE; the earliest new grant is evaluated in the following IDLE cycle.
- Requester drops its request while in BUSY: the transaction still completes and resp still pulses.
- The non-granted requester never sees resp; its X_rdata holds its previous value.
- Back-to-back ties alternate I/D/I/D; no requester waits more than one transaction.
- pmem_resp in IDLE or DONE is ignored.
- Throughput: minimum 3 cycles per transaction plus memory latency.

Decomposition:
- Package cache_arb_types:
  - state enum {IDLE, BUSY, DONE}
  - requester enum {REQ_I, REQ_D}
  - default widths
- Optional sub-module arb_rr2: 2-way round-robin picker with the last_grant register, shared later by other arbiters. The FSM and datapath registers stay in cache_arbiter.

Test Plan:
- I read only: i_address=0x1000_0040, i_read=1 -> pmem_read=1 and pmem_address=0x1000_0040 next cycle. Memory returns pmem_rdata=0xAA..AA with resp at cycle 5 -> i_rdata=0xAA..AA and i_resp=1 at cycle 6 only; d_resp stays 0.
- Simultaneous requests after reset: i_read @0x100, d_write @0x200 with wdata=0x55..55 -> D served first (pmem_write, 0x200, 0x55..55); I served next @0x100. Repeated ties alternate grants.
- Same requester asserts read+write @0x300 -> pmem_write=1, pmem_read=0.
- Mid-BUSY: d_address changes 0x200->0x400 and i_read rises -> pmem_address stays 0x200 until pmem_resp. I is granted only after DONE, at ≥2 cycles after d_resp.
- Reset mid-op: rst=0 during BUSY -> all outputs 0 immediately. A pmem_resp arriving after reset release produces no X_resp.
- Spurious pmem_resp in IDLE -> no i_resp/d_resp, no state change.
